// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU decoder and the multi-cycle execution unit:
//   - ALU_ADD..ALU_AND : 4-bit ALU control codes produced by the decoder
//   - ALUOP_*          : 2-bit ALUOp class constants from the main controller
//   - ALU_XLEN         : operand/result width
//   - ALU_SHAMT_W      : shift-amount width (taken from src_b low bits)
//   - state_e          : execution-unit FSM states
//   - shift_mode_e     : shift direction/fill selector for alu_shift_unit
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_XLEN    = 32;
   localparam int ALU_SHAMT_W = 5;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   // ALUOp classes driven by the main controller into the ALU decoder.
   localparam logic [1:0] ALUOP_MEM    = 2'b00;  // address add
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // compare via subtract
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;  // decode funct3/funct7

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SH_LL = 2'd0,
      SH_RL = 2'd1,
      SH_RA = 2'd2
   } shift_mode_e;

   function automatic logic is_shift_op(input logic [3:0] code);
      return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
   endfunction

   function automatic shift_mode_e shift_mode_of(input logic [3:0] code);
      case (code)
         ALU_SRL: return SH_RL;
         ALU_SRA: return SH_RA;
         default: return SH_LL;
      endcase
   endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// ---------------------------------------------------------------------------
// alu_shift_unit
// Shifter for the execution unit. Default build: iterative, one bit per
// cycle. With ALU_EXEC_SEQ_FAST_SHIFT_EN defined: combinational barrel
// shifter that always finishes in the start cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : latch data_in/shamt_in/mode (one-cycle pulse)
//   mode       : SH_LL / SH_RL / SH_RA
//   data_in    : value to shift
//   shamt_in   : shift amount
//   busy       : shift in progress (counter non-zero)
//   done       : result is final this cycle; caller registers it
//   result     : shifted value, valid while done is high
// ---------------------------------------------------------------------------
module alu_shift_unit
   import alu_pkg::*;
#(
   parameter int XLEN    = ALU_XLEN,
   parameter int SHAMT_W = ALU_SHAMT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  shift_mode_e        mode,
   input  logic [XLEN-1:0]    data_in,
   input  logic [SHAMT_W-1:0] shamt_in,
   output logic               busy,
   output logic               done,
   output logic [XLEN-1:0]    result
);

`ifdef ALU_EXEC_SEQ_FAST_SHIFT_EN

   // Kept so the port shape matches the iterative build; never set.
   logic busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= 1'b0;
      else     busy_q <= 1'b0;
   end

   always_comb begin
      result = data_in;
      case (mode)
         SH_LL:   result = data_in << shamt_in;
         SH_RL:   result = data_in >> shamt_in;
         SH_RA:   result = $unsigned($signed(data_in) >>> shamt_in);
         default: result = data_in;
      endcase
   end

   assign busy = busy_q;
   assign done = start;

`else

   logic [XLEN-1:0]    data_q;
   logic [SHAMT_W-1:0] cnt_q;
   shift_mode_e        mode_q;

   function automatic logic [XLEN-1:0] step(input logic [XLEN-1:0] d,
                                            input shift_mode_e     m);
      case (m)
         SH_RL:   return {1'b0, d[XLEN-1:1]};
         SH_RA:   return {d[XLEN-1], d[XLEN-1:1]};
         default: return {d[XLEN-2:0], 1'b0};
      endcase
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         cnt_q  <= '0;
         mode_q <= SH_LL;
      end else if (start) begin
         data_q <= data_in;
         cnt_q  <= shamt_in;
         mode_q <= mode;
      end else if (cnt_q != '0) begin
         data_q <= step(data_q, mode_q);
         cnt_q  <= cnt_q - SHAMT_W'(1);
      end
   end

   // A zero shift finishes in the start cycle; otherwise the edge that takes
   // the counter from 1 to 0 performs the last step, so its output is final.
   assign busy   = (cnt_q != '0);
   assign done   = (start && (shamt_in == '0)) || (cnt_q == SHAMT_W'(1));
   assign result = start ? data_in : step(data_q, mode_q);

`endif

endmodule

// File: rtl/alu_exec_seq.sv
// ---------------------------------------------------------------------------
// alu_exec_seq
// Multi-cycle execution unit between register read and writeback/branch.
// Non-shift ops complete in one cycle; shifts go through alu_shift_unit
// (iterative by default, barrel when ALU_EXEC_SEQ_FAST_SHIFT_EN is defined).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : operation offered       in_ready  : operation accepted
//   alu_control : 4-bit ALU code (alu_pkg ALU_*; 10-15 act as ADD)
//   src_a/src_b : operands (shift amount in src_b[4:0])
//   out_valid   : result available        out_ready : consumer takes result
//   result      : registered result       zero      : registered result==0
// ---------------------------------------------------------------------------
module alu_exec_seq
   import alu_pkg::*;
#(
   parameter int XLEN    = ALU_XLEN,
   parameter int SHAMT_W = ALU_SHAMT_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_control,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] result_q, load_val, alu_val;
   logic            zero_q, load, accept;
   logic            sh_start, sh_busy, sh_done;
   logic [XLEN-1:0] sh_result;

   alu_shift_unit #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_shift (
      .clk      (clk),
      .rst      (rst),
      .start    (sh_start),
      .mode     (shift_mode_of(alu_control)),
      .data_in  (src_a),
      .shamt_in (src_b[SHAMT_W-1:0]),
      .busy     (sh_busy),
      .done     (sh_done),
      .result   (sh_result)
   );

   // Shift codes never reach this result (they are routed to the shifter),
   // so they share the ADD fallback with codes 10-15.
   always_comb begin
      case (alu_control)
         ALU_SUB:  alu_val = src_a - src_b;
         ALU_SLT:  alu_val = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         ALU_SLTU: alu_val = {{(XLEN-1){1'b0}}, (src_a < src_b)};
         ALU_XOR:  alu_val = src_a ^ src_b;
         ALU_OR:   alu_val = src_a | src_b;
         ALU_AND:  alu_val = src_a & src_b;
         default:  alu_val = src_a + src_b;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      load_val = alu_val;
      sh_start = 1'b0;
      in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
      accept   = in_valid && in_ready;

      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               if (is_shift_op(alu_control)) begin
                  sh_start = 1'b1;
                  if (sh_done) begin
                     load     = 1'b1;
                     load_val = sh_result;
                     state_d  = DONE;
                  end else begin
                     state_d  = SHIFT;
                  end
               end else begin
                  load    = 1'b1;
                  state_d = DONE;
               end
            end else if (state_q == DONE && out_ready) begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (sh_done) begin
               load     = 1'b1;
               load_val = sh_result;
               state_d  = DONE;
            end else if (!sh_busy) begin
               state_d  = IDLE;  // shifter lost its operation; recover
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q <= '0;
         zero_q   <= 1'b1;
      end else if (load) begin
         result_q <= load_val;
         zero_q   <= (load_val == '0);
      end
   end

   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_seq
// Directed self-checking bench for alu_exec_seq. Expected latencies follow
// the build: shamt+1 cycles for iterative shifts, 1 cycle otherwise.
// ---------------------------------------------------------------------------
module tb_alu_exec_seq;
   import alu_pkg::*;

`ifdef ALU_EXEC_SEQ_FAST_SHIFT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, zero;
   logic [3:0]  alu_control;
   logic [31:0] src_a, src_b, result;

   int n_checks = 0;
   int n_fail   = 0;

   alu_exec_seq dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_control (alu_control),
      .src_a       (src_a),
      .src_b       (src_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op with out_ready=1, wait (bounded) for the result, check it,
   // then let the handshake retire it.
   task automatic do_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat_iter);
      int lat;
      int exp_lat;
      exp_lat     = FAST ? 1 : lat_iter;
      alu_control = op;
      src_a       = a;
      src_b       = b;
      in_valid    = 1'b1;
      out_ready   = 1'b1;
      check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 64) begin
         check({tag, ".busy_in_ready"}, {31'd0, in_ready}, 32'd0);
         step();
         lat++;
      end
      check({tag, ".latency"}, lat, exp_lat);
      check({tag, ".result"}, result, exp);
      check({tag, ".zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
      step();
      check({tag, ".retired"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      alu_control = ALU_ADD;
      src_a       = '0;
      src_b       = '0;
      #3;
      check("rst.out_valid", {31'd0, out_valid}, 32'd0);
      check("rst.result",    result, 32'd0);
      check("rst.zero",      {31'd0, zero}, 32'd1);
      check("rst.in_ready",  {31'd0, in_ready}, 32'd1);
      step();
      rst = 1'b0;
      step();

      do_op("sub",      ALU_SUB,  32'd5,          32'd5,          32'h0000_0000, 1);
      do_op("slt",      ALU_SLT,  32'hFFFF_FFFF,  32'd1,          32'h0000_0001, 1);
      do_op("sltu",     ALU_SLTU, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1);
      do_op("sra3",     ALU_SRA,  32'h8000_0000,  32'h0000_0023,  32'hF000_0000, 4);
      do_op("sll0",     ALU_SLL,  32'h1234_5678,  32'h0000_0000,  32'h1234_5678, 1);
      do_op("sll0_hi",  ALU_SLL,  32'h1234_5678,  32'h0000_0020,  32'h1234_5678, 1);
      do_op("add_wrap", ALU_ADD,  32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1);
      do_op("or",       ALU_OR,   32'hA000_0005,  32'h0500_0050,  32'hA500_0055, 1);
      do_op("code12",   4'd12,    32'd100,        32'd23,         32'd123,       1);
      do_op("srl31",    ALU_SRL,  32'h8000_0000,  32'd31,         32'h0000_0001, 32);
      do_op("sll31",    ALU_SLL,  32'h0000_0001,  32'd31,         32'h8000_0000, 32);

      // Back-pressure: AND result held while a pending XOR is offered.
      out_ready   = 1'b0;
      alu_control = ALU_AND;
      src_a       = 32'hF0F0_F0F0;
      src_b       = 32'h0FF0_0FF0;
      in_valid    = 1'b1;
      step();
      alu_control = ALU_XOR;
      src_a       = 32'hFFFF_0000;
      src_b       = 32'h00FF_FF00;
      for (int i = 0; i < 5; i++) begin
         check("bp.out_valid", {31'd0, out_valid}, 32'd1);
         check("bp.result",    result, 32'h00F0_00F0);
         check("bp.in_ready",  {31'd0, in_ready}, 32'd0);
         step();
      end
      out_ready = 1'b1;
      #1;
      check("handoff.in_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      check("handoff.out_valid", {31'd0, out_valid}, 32'd1);
      check("handoff.result",    result, 32'hFF00_FF00);
      check("handoff.zero",      {31'd0, zero}, 32'd0);
      step();
      check("handoff.retired",   {31'd0, out_valid}, 32'd0);

      // Reset in the middle of a 20-bit shift.
      alu_control = ALU_SLL;
      src_a       = 32'h0000_0001;
      src_b       = 32'd20;
      in_valid    = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) step();
      rst = 1'b1;
      #1;
      check("midrst.out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst.result",    result, 32'd0);
      check("midrst.zero",      {31'd0, zero}, 32'd1);
      check("midrst.in_ready",  {31'd0, in_ready}, 32'd1);
      step();
      rst = 1'b0;
      step();
      do_op("post_rst", ALU_ADD, 32'd2, 32'd3, 32'd5, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
      $finish;
   end

endmodule
